// File: rtl/mul_pkg.sv
// mul_pkg: shared multiply opcode and sequencer state types
package mul_pkg;
   typedef enum logic [1:0] {MUL_LO = 2'b00, MULH = 2'b01, MULHSU = 2'b10, MULHU = 2'b11} mul_op_e;
   typedef enum logic [1:0] {IDLE, CALC, DONE} mul_state_e;
endpackage

// File: rtl/mul_seq.sv
// mul_seq: radix-2 shift-add N x N multiplier with RV32M-style high/low modes
module mul_seq
   import mul_pkg::*;
#(
   parameter int N = 16,
   localparam int CW = $clog2(N + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   mul_op,
   input  logic [N-1:0] rs1_reg,
   input  logic [N-1:0] rs2_reg,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] mul_rd
);
   mul_state_e state, state_d;
   mul_op_e op, op_in;
   logic [2*N-1:0] acc, acc_nx, prod;
   logic [N-1:0] mcand, mag1, mag2;
   logic [N:0] sum;
   logic [CW-1:0] cnt;
   logic s1, s2, neg, last;
   always_comb begin
      op_in = mul_op_e'(mul_op);
      s1 = rs1_reg[N-1] & (op_in == MULH || op_in == MULHSU);
      s2 = rs2_reg[N-1] & (op_in == MULH);
      mag1 = s1 ? -rs1_reg : rs1_reg;
      mag2 = s2 ? -rs2_reg : rs2_reg;
      // multiplier lives in the low half and is consumed as product bits shift in
      sum = {1'b0, acc[2*N-1:N]} + {1'b0, acc[0] ? mcand : {N{1'b0}}};
      acc_nx = {sum, acc[N-1:1]};
      prod = neg ? -acc_nx : acc_nx;
      last = cnt == CW'(N - 1);
      state_d = flush ? IDLE :
                state == IDLE ? (in_valid ? CALC : IDLE) :
                state == CALC ? (last ? DONE : CALC) :
                (out_ready ? IDLE : DONE);
   end
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         acc <= '0;
         cnt <= '0;
         mcand <= '0;
         neg <= 1'b0;
         op <= MUL_LO;
         mul_rd <= '0;
      end else begin
         state <= state_d;
         if (state == IDLE && in_valid && !flush) begin
            mcand <= mag1;
            acc <= {{N{1'b0}}, mag2};
            neg <= s1 ^ s2;
            op <= op_in;
            cnt <= '0;
         end else if (state == CALC) begin
            acc <= acc_nx;
            cnt <= cnt + CW'(1);
            if (last && !flush) mul_rd <= op == MUL_LO ? prod[N-1:0] : prod[2*N-1:N];
         end
      end
   end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed vector table plus handshake, flush and reset sequences
module tb_mul_seq;
   logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic in_ready, out_valid;
   logic [1:0] mul_op = 2'b00;
   logic [15:0] rs1_reg = '0, rs2_reg = '0, mul_rd;
   int checks = 0, errors = 0;
   mul_seq #(.N(16)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .mul_op(mul_op), .rs1_reg(rs1_reg), .rs2_reg(rs2_reg), .out_valid(out_valid),
      .out_ready(out_ready), .mul_rd(mul_rd)
   );
   always #5 clk = ~clk;
   typedef struct {logic [1:0] op; logic [15:0] a, b, exp;} vec_t;
   vec_t vecs[13];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic logic [15:0] ref_mul(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [63:0] sa, sb, p;
      sa = {{48{a[15] & (op == 2'b01 || op == 2'b10)}}, a};
      sb = {{48{b[15] & (op == 2'b01)}}, b};
      p = sa * sb;
      return op == 2'b00 ? p[15:0] : p[31:16];
   endfunction
   // call at a negedge while idle; returns at the negedge where out_valid is first seen
   task automatic run(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      output logic [15:0] r, output int lat);
      mul_op = op;
      rs1_reg = a;
      rs2_reg = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
      end
      r = mul_rd;
   endtask
   initial begin
      logic [15:0] r, hold, a, b;
      logic [1:0] op;
      int lat, pulses;
      vecs = '{
         '{2'b00, 16'h1234, 16'h0010, 16'h2340},
         '{2'b01, 16'h8000, 16'h8000, 16'h4000},
         '{2'b01, 16'hFFFF, 16'h0002, 16'hFFFF},
         '{2'b00, 16'hFFFF, 16'h0002, 16'hFFFE},
         '{2'b11, 16'hFFFF, 16'hFFFF, 16'hFFFE},
         '{2'b00, 16'hFFFF, 16'hFFFF, 16'h0001},
         '{2'b10, 16'hFFFF, 16'hFFFF, 16'hFFFF},
         '{2'b10, 16'h7FFF, 16'hFFFF, 16'h7FFE},
         '{2'b01, 16'h8000, 16'h7FFF, 16'hC000},
         '{2'b00, 16'h8000, 16'h7FFF, 16'h8000},
         '{2'b11, 16'h0000, 16'hFFFF, 16'h0000},
         '{2'b00, 16'h0003, 16'hFFFD, 16'hFFF7},
         '{2'b01, 16'hFFFF, 16'hFFFF, 16'h0000}
      };
      repeat (2) @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_mul_rd", mul_rd, 0);
      rst_n = 1'b1;
      @(negedge clk);
      foreach (vecs[i]) begin
         run(vecs[i].op, vecs[i].a, vecs[i].b, r, lat);
         chk($sformatf("vec%0d_result", i), r, vecs[i].exp);
         chk($sformatf("vec%0d_latency", i), lat, 17);
         @(negedge clk);
         chk($sformatf("vec%0d_ready_after", i), {in_ready, out_valid}, 2'b10);
      end
      for (int i = 0; i < 8; i++) begin
         op = 2'($urandom_range(3, 0));
         a = 16'($urandom);
         b = 16'($urandom);
         run(op, a, b, r, lat);
         chk($sformatf("rand%0d_op%0d_%h_%h", i, op, a, b), r, ref_mul(op, a, b));
         @(negedge clk);
      end
      out_ready = 1'b0;
      run(2'b11, 16'h1234, 16'h5678, r, lat);
      chk("bp_result", r, 16'h0626);
      hold = r;
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         rs1_reg = 16'h0003;
         @(negedge clk);
         chk($sformatf("bp%0d_state", i), {out_valid, in_ready}, 2'b10);
         chk($sformatf("bp%0d_hold", i), mul_rd, hold);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_retire", {in_ready, out_valid}, 2'b10);
      run(2'b00, 16'h0009, 16'h0007, r, lat);
      chk("b2b_result", r, 16'h003F);
      chk("b2b_latency", lat, 17);
      @(negedge clk);
      mul_op = 2'b00;
      rs1_reg = 16'h0005;
      rs2_reg = 16'h0007;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush_idle", {in_ready, out_valid}, 2'b10);
      pulses = 0;
      repeat (20) begin
         @(negedge clk);
         pulses += int'(out_valid);
      end
      chk("flush_no_valid", pulses, 0);
      chk("flush_rd_kept", mul_rd, 16'h003F);
      in_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      flush = 1'b0;
      chk("flush_beats_valid", in_ready, 1);
      @(negedge clk);
      run(2'b01, 16'hFFFB, 16'h0007, r, lat);
      chk("post_flush_result", r, 16'hFFFF);
      @(negedge clk);
      run(2'b00, 16'hFFFB, 16'h0007, r, lat);
      chk("neg_low_result", r, 16'hFFDD);
      @(negedge clk);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      chk("midreset_outputs", {in_ready, out_valid, mul_rd}, {2'b10, 16'h0000});
      @(negedge clk);
      run(2'b11, 16'h0100, 16'h0100, r, lat);
      chk("post_reset_result", r, 16'h0001);
      chk("post_reset_latency", lat, 17);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
